// File: rtl/fir_pkg.sv
// fir_pkg: FIR engine constants, FSM state encoding and output scaling; FIR_ROUND_SAT_EN selects round-half-up plus saturation
package fir_pkg;
  localparam int NUMTABS       = 64;
  localparam int COUNT_BIT_NUM = $clog2(NUMTABS);
  localparam int DATA_W        = 16;
  localparam int COEF_W        = 16;
  localparam int PROD_W        = DATA_W + COEF_W;
  localparam int ACC_W         = PROD_W + COUNT_BIT_NUM;
  localparam int OUT_SHIFT     = 15;
`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
`endif
  typedef enum logic [1:0] {IDLE, MAC, FLUSH, DONE} state_t;
  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
`ifdef FIR_ROUND_SAT_EN
    s = (a + RND) >>> OUT_SHIFT;
    return s > MAXV ? MAXV[DATA_W-1:0] : s < MINV ? MINV[DATA_W-1:0] : s[DATA_W-1:0];
`else
    s = a >>> OUT_SHIFT;
    return s[DATA_W-1:0];
`endif
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: NUMTABS-deep circular sample buffer, synchronous write and clear, combinational read
module fir_delay_line
  import fir_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_we,
  input  logic        [COUNT_BIT_NUM-1:0] i_wr_addr,
  input  logic signed [DATA_W-1:0]        i_wr_data,
  input  logic        [COUNT_BIT_NUM-1:0] i_rd_addr,
  output logic signed [DATA_W-1:0]        o_rd_data
);
  logic signed [DATA_W-1:0] r_mem [NUMTABS];
  // store accepted samples; reset clears the whole history
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUMTABS; i++) r_mem[i] <= '0;
    else if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end
  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/fir_mac_serial.sv
// fir_mac_serial: serial 64-tap FIR, one MAC per cycle against an external coefficient ROM (build with FIR_ROUND_SAT_EN for rounding/saturation)
module fir_mac_serial
  import fir_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [DATA_W-1:0]        in_data,
  output logic        [COUNT_BIT_NUM-1:0] count,
  input  logic signed [COEF_W-1:0]        coeffs_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [DATA_W-1:0]        out_data,
  output logic                            busy
);
  state_t                           r_state, w_next;
  logic        [COUNT_BIT_NUM-1:0]  r_count, r_wr_ptr, r_newest, w_rd_addr;
  logic signed [DATA_W-1:0]         w_rd_data, r_out_data;
  logic signed [PROD_W-1:0]         r_prod;
  logic signed [ACC_W-1:0]          r_acc, w_acc_next;
  logic                             w_accept;
  assign in_ready   = r_state == IDLE;
  assign busy       = !in_ready;
  assign out_valid  = r_state == DONE;
  assign out_data   = r_out_data;
  assign count      = r_count;
  assign w_accept   = in_valid && in_ready;
  assign w_rd_addr  = r_newest - r_count;
  assign w_acc_next = r_acc + ACC_W'(r_prod);
  fir_delay_line u_dl (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );
  // state register
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // next state: one sample in flight at a time, result held until accepted
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_accept ? MAC : IDLE;
      MAC:     w_next = r_count == COUNT_BIT_NUM'(NUMTABS - 1) ? FLUSH : MAC;
      FLUSH:   w_next = DONE;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // datapath: product register pipelines the multiply, FLUSH folds in the last product and scales
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_newest   <= '0;
      r_acc      <= '0;
      r_prod     <= '0;
      r_out_data <= '0;
    end else begin
      if (w_accept) begin
        r_newest <= r_wr_ptr;
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_acc    <= '0;
        r_prod   <= '0;
        r_count  <= '0;
      end
      if (r_state == MAC) begin
        r_prod  <= coeffs_in * w_rd_data;
        r_acc   <= w_acc_next;
        r_count <= r_count + 1'b1;
      end
      if (r_state == FLUSH) begin
        r_acc      <= w_acc_next;
        r_out_data <= scale(w_acc_next);
      end
    end
  end
endmodule
